// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sweeper and the gate library.
// Optional majority-vote sampling in the sweeper is enabled by SWEEP_MAJORITY_EN.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } sweep_state_e;

    localparam int unsigned N_COMBOS   = 8;
    localparam logic [2:0]  LAST_COMBO = 3'(N_COMBOS - 1);

    // Hex-name convention: input combination 000 lands in the table MSB.
    function automatic logic [2:0] tt_bit_index(input logic [2:0] combo);
        return 3'd7 - combo;
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Loadable down-counter with a zero flag, used to time slow-gate settle windows.
module tt_settle_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; the count holds otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 8 input combinations into a 3-input gate, samples its output after a
// settle window and compares the assembled truth table with a golden value.
// Define SWEEP_MAJORITY_EN to take a 2-of-3 vote over the last three window cycles.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [7:0] mismatch,
    output logic       pass
);

    sweep_state_e     r_state;
    logic [2:0]       r_combo;
    logic [7:0]       r_expected;
    logic [7:0]       r_table;
    logic [7:0]       r_mismatch;
    logic             r_pass;

    logic [CNT_W-1:0] w_count;
    logic             w_zero;
    logic             w_load;
    logic             w_dec;
    logic             w_accept;
    logic             w_sample;
    logic [7:0]       w_table_next;

    assign w_accept = (r_state == IDLE) && start;
    // Reload at start and at every window end except the last; abort suppresses the reload.
    assign w_load   = w_accept ||
                      ((r_state == SETTLE) && !abort && w_zero && (r_combo != LAST_COMBO));
    assign w_dec    = (r_state == SETTLE) && (w_count != '0);

    tt_settle_counter #(
        .CNT_W (CNT_W)
    ) u_settle_counter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

`ifdef SWEEP_MAJORITY_EN
    logic [1:0] r_vote;

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SWEEP_MAJORITY_EN requires SETTLE_CYCLES >= 3");
    end

    // Collect the samples taken at counter 2 and 1; abort throws them away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vote <= '0;
        end else if ((r_state == SETTLE) && abort) begin
            r_vote <= '0;
        end else if (r_state == SETTLE) begin
            if (w_count == CNT_W'(2)) r_vote[1] <= dut_out;
            if (w_count == CNT_W'(1)) r_vote[0] <= dut_out;
        end
    end

    assign w_sample = (r_vote[1] & r_vote[0]) | (r_vote[1] & dut_out) | (r_vote[0] & dut_out);
`else
    assign w_sample = dut_out;
`endif

    // Table value after writing the current combination's sample.
    always_comb begin
        w_table_next = r_table;
        w_table_next[tt_bit_index(r_combo)] = w_sample;
    end

    // Sweep sequencing, result capture and comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_combo    <= '0;
            r_expected <= '0;
            r_table    <= '0;
            r_mismatch <= '0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_expected <= expected;
                        r_table    <= '0;
                        r_mismatch <= '0;
                        r_pass     <= 1'b0;
                        r_combo    <= '0;
                        r_state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_zero) begin
                        r_table <= w_table_next;
                        if (r_combo == LAST_COMBO) begin
                            r_mismatch <= w_table_next ^ r_expected;
                            r_pass     <= ((w_table_next ^ r_expected) == 8'h00);
                            r_state    <= DONE;
                        end else begin
                            r_combo <= r_combo + 3'd1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign {in1, in2, in3} = (r_state == SETTLE) ? r_combo : 3'b000;
    assign busy            = (r_state == SETTLE);
    assign done            = (r_state == DONE);
    assign table_out       = r_table;
    assign mismatch        = r_mismatch;
    assign pass            = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper driving a modelled gate (out=1 for 000, 110).
module tb_truth_table_sweeper;

    localparam int unsigned S = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       dut_out;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic [7:0] mismatch;
    logic       pass;
    logic       glitch;

    int n_err;
    int n_chk;

    truth_table_sweeper #(
        .SETTLE_CYCLES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .expected  (expected),
        .dut_out   (dut_out),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .mismatch  (mismatch),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under control, with a forced-low glitch input.
    always_comb begin
        dut_out = (({in1, in2, in3} == 3'b000) || ({in1, in2, in3} == 3'b110)) && !glitch;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full sweep from IDLE. glitch_idx selects one window cycle (c*S+s) to pull the gate low;
    // poke re-pulses start mid-sweep and in DONE with a different golden value.
    task automatic sweep(input logic [7:0] exp_in, input logic [7:0] exp_table,
                         input int glitch_idx, input bit poke);
        logic [7:0] exp_mm;
        exp_mm = exp_table ^ exp_in;
        @(negedge clk);
        start    = 1'b1;
        expected = exp_in;
        @(negedge clk);
        start    = 1'b0;
        expected = 8'hff;
        for (int c = 0; c < 8; c++) begin
            for (int s = 0; s < int'(S); s++) begin
                glitch = ((c * int'(S) + s) == glitch_idx);
                start  = poke && ((c * int'(S) + s) == 5 || (c * int'(S) + s) == 20);
                check("inputs", {5'd0, in1, in2, in3}, 8'(c));
                check("busy", {7'd0, busy}, 8'd1);
                check("done_early", {7'd0, done}, 8'd0);
                @(negedge clk);
            end
        end
        glitch = 1'b0;
        start  = poke;
        check("done", {7'd0, done}, 8'd1);
        check("busy_done", {7'd0, busy}, 8'd0);
        check("inputs_done", {5'd0, in1, in2, in3}, 8'd0);
        check("table", table_out, exp_table);
        check("mismatch", mismatch, exp_mm);
        check("pass", {7'd0, pass}, {7'd0, exp_mm == 8'h00});
        @(negedge clk);
        start = 1'b0;
        check("done_clear", {7'd0, done}, 8'd0);
        check("busy_idle", {7'd0, busy}, 8'd0);
        check("table_hold", table_out, exp_table);
        check("mismatch_hold", mismatch, exp_mm);
    endtask

    initial begin
        int n_done;
        n_err    = 0;
        n_chk    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        expected = 8'h00;
        glitch   = 1'b0;
        #1;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_inputs", {5'd0, in1, in2, in3}, 8'd0);
        check("rst_table", table_out, 8'h00);
        check("rst_mismatch", mismatch, 8'h00);
        check("rst_pass", {7'd0, pass}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Matching golden value.
        sweep(8'h82, 8'h82, -1, 1'b0);
        // Non-matching golden value, with ignored start pulses mid-sweep and in DONE.
        sweep(8'h80, 8'h82, -1, 1'b1);

        // Glitch at counter==1 of combination 000 never reaches the table.
        sweep(8'h82, 8'h82, int'(S) - 2, 1'b0);
        // Glitch on the final window cycle: single sample sees it, majority outvotes it.
`ifdef SWEEP_MAJORITY_EN
        sweep(8'h82, 8'h82, int'(S) - 1, 1'b0);
`else
        sweep(8'h82, 8'h02, int'(S) - 1, 1'b0);
`endif

        // start and abort together in IDLE: start wins; later abort mid combination 011.
        @(negedge clk);
        start    = 1'b1;
        abort    = 1'b1;
        expected = 8'h82;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", {7'd0, busy}, 8'd1);
        repeat (3 * S + 1) @(negedge clk);
        check("abort_pre_inputs", {5'd0, in1, in2, in3}, 8'h03);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_inputs", {5'd0, in1, in2, in3}, 8'd0);
        check("abort_done", {7'd0, done}, 8'd0);
        check("abort_pass", {7'd0, pass}, 8'd0);
        check("abort_partial", table_out, 8'h80);
        n_done = 0;
        for (int i = 0; i < 8 * int'(S) + 4; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", 8'(n_done), 8'd0);

        // Abort coinciding with the first sample edge: nothing is written.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_edge_table", table_out, 8'h00);
        check("abort_edge_busy", {7'd0, busy}, 8'd0);

        // Asynchronous reset mid-sweep, in combination 010 with bit 7 already captured.
        @(negedge clk);
        start    = 1'b1;
        expected = 8'h82;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * S + 2) @(negedge clk);
        check("pre_rst_table", table_out, 8'h80);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_inputs", {5'd0, in1, in2, in3}, 8'd0);
        check("mid_rst_table", table_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sweep(8'h82, 8'h82, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that characterises one 3-input combinational logic gate (in1, in2, in3 -> out) by driving all 8 input combinations in order.
- After a programmable settle time per combination, it samples the gate output and assembles an 8-bit truth-table word in the team's hex-name convention (MSB = input 000).
- It compares the word against an expected value, e.g. 8'h82.
- Sits between a test/config controller and any gate-library block, replacing manual stimulus.

Parameters:
- SETTLE_CYCLES, 4, cycles each input combination is held; the sample is taken in the last of them; legal range 1..65535.
- CNT_W, $clog2(SETTLE_CYCLES+1), width of settle counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  cancels an in-progress sweep.
- expected  input  8  golden truth table; sampled at accepted start.
- dut_out  input  1  output of the gate under control.
- in1  output  1  gate input MSB.
- in2  output  1  gate input middle bit.
- in3  output  1  gate input LSB.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  8  captured truth table.
- mismatch  output  8  table_out XOR latched expected; valid from done onward.
- pass  output  1  high when mismatch == 0; valid from done onward.

Behaviour:
Reset values (asynchronous, immediate on rst):
- State IDLE.
- {in1,in2,in3} = 3'b000.
- busy = 0, done = 0, table_out = 0, mismatch = 0, pass = 0.

States: IDLE, SETTLE, DONE.

IDLE:
- {in1,in2,in3} = 000.
- start=1 at edge k: latch expected, clear table_out/mismatch/pass, combo=0, counter=SETTLE_CYCLES-1, go to SETTLE.
- busy=1 from cycle k+1.

SETTLE:
- {in1,in2,in3} = combo.
- counter decrements each cycle.
- At the edge where counter==0: table_out[7-combo] <= dut_out.
- If combo==7, go to DONE; else combo+1 and reload counter.
- Each combination is held exactly SETTLE_CYCLES cycles.

DONE:
- Lasts one cycle: done=1, busy=0.
- mismatch/pass are updated at the edge entering DONE, so they are valid while done=1.
- Then return to IDLE.
- Total latency: done is high in cycle k+1+8*SETTLE_CYCLES.
- table_out, mismatch and pass hold until the next accepted start.

Boundary conditions:
- start while busy or in DONE: ignored, with no effect on the current sweep.
- abort in SETTLE (including same cycle as a sample edge): abort wins; no sample is written; go to IDLE next cycle with inputs 000, busy=0, and no done pulse. table_out keeps partial bits; pass=0.
- abort in IDLE/DONE: ignored.
- start and abort both high in IDLE: start accepted, abort ignored that cycle.
- rst mid-sweep: immediate return to reset values.
- SETTLE_CYCLES=1: one cycle per combination; done at k+9.

Optional Feature:
Macro SWEEP_MAJORITY_EN.
- Defined:
  - Samples dut_out on the last 3 cycles of each window (counter 2,1,0).
  - table_out[7-combo] = majority of the 3 samples.
  - Requires SETTLE_CYCLES>=3; elaboration error ($error) otherwise.
  - Abort discards partial votes.
- Undefined: single sample at counter==0 as described above; no vote registers.

Decomposition:
- Package truth_table_pkg holds:
  - state enum sweep_state_e {IDLE, SETTLE, DONE};
  - localparam N_COMBOS = 8;
  - function tt_bit_index(combo) = 7 - combo, shared with the gate library.
- One natural sub-module: tt_settle_counter (load/decrement/zero flag, CNT_W wide), reused for other slow-gate timing.
- The majority voter stays inline.

Test Plan:
- Gate model out=1 only for inputs 000 and 110; SETTLE_CYCLES=4, expected=8'h82, start at cycle 10 -> inputs step 000..111 every 4 cycles; done pulse at cycle 43; table_out=8'h82, mismatch=8'h00, pass=1.
- Same gate, expected=8'h80 -> table_out=8'h82, mismatch=8'h02, pass=0.
- abort asserted at cycle 25 (mid combination 011) -> cycle 26: IDLE, inputs 000, busy=0; no done pulse; pass=0.
- start pulsed again at cycles 15 and 30 during a sweep -> ignored; single done at cycle 43.
- rst asserted at cycle 20 mid-sweep -> outputs zero asynchronously; later start produces a clean full sweep with table_out=8'h82.
- With SWEEP_MAJORITY_EN: dut_out glitches low for 1 cycle at counter==1 of combination 000 -> table_out still 8'h82, pass=1.
